// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI IN receive path:
//   - MIDI status byte constants
//   - midi_data_len(): number of data bytes that follow a channel status byte
//   - midi_byte_class(): coarse classification of a received byte
//   - rx_state_t: byte receiver FSM states
// -----------------------------------------------------------------------------
package midi_pkg;

    localparam logic [7:0] MIDI_CC      = 8'hB0;
    localparam logic [7:0] MIDI_PC      = 8'hC0;
    localparam logic [7:0] MIDI_NOTE_ON = 8'h90;
    localparam logic [7:0] MIDI_SYSEX   = 8'hF0;
    localparam logic [7:0] MIDI_EOX     = 8'hF7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Data bytes (0x00-0x7F), channel status (0x80-0xEF),
    // system common / SysEx (0xF0-0xF7), real-time (0xF8-0xFF).
    typedef enum logic [1:0] {
        BC_DATA = 2'd0,
        BC_CHAN = 2'd1,
        BC_SYS  = 2'd2,
        BC_RT   = 2'd3
    } byte_class_t;

    // Program change (0xCn) and channel pressure (0xDn) carry one data byte.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        case (status[7:4])
            4'hC, 4'hD: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

    function automatic byte_class_t midi_byte_class(input logic [7:0] b);
        if (b[7] == 1'b0) begin
            return BC_DATA;
        end else if (b[7:4] != 4'hF) begin
            return BC_CHAN;
        end else if (b[3] == 1'b1) begin
            return BC_RT;
        end else begin
            return BC_SYS;
        end
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
// 8N1 serial byte receiver with a 2-flop input synchronizer.
//   clk        system clock
//   rst        asynchronous reset, active-low
//   rx         asynchronous serial line, idle high
//   byte_valid one-cycle strobe, byte_data holds the received byte
//   byte_data  last good byte
//   frame_err  one-cycle strobe, stop bit sampled low (byte discarded)
// Bits are sampled mid-bit: the start bit is re-checked half a bit after the
// falling edge, then every BAUD_CNT cycles.
// -----------------------------------------------------------------------------
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int BAUD_CNT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic            sync1_r;
    logic            rx_s;
    rx_state_t       state_r;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      bit_r;
    logic [7:0]      shift_r;

    // Two-stage synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    // Byte receiver FSM with registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_r   <= HALF_LOAD;
                        state_r <= START;
                    end
                end
                START: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (rx_s) begin
                            // Line back high at mid start bit: glitch.
                            state_r <= IDLE;
                        end else begin
                            cnt_r   <= FULL_LOAD;
                            bit_r   <= 3'd0;
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_ZERO) begin
                        shift_r <= {rx_s, shift_r[7:1]};   // LSB first
                        cnt_r   <= FULL_LOAD;
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_r;
                            state_r    <= IDLE;
                        end else begin
                            // Low stop bit: wait for the line to recover so a
                            // held-low line is not mistaken for a new start.
                            frame_err <= 1'b1;
                            state_r   <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/midi_rx_parser.sv
// -----------------------------------------------------------------------------
// midi_rx_parser
// MIDI IN receiver: serial line to complete channel messages.
//   clk        system clock
//   rst        asynchronous reset, active-low
//   midi_rx    asynchronous serial MIDI line, idle high
//   msg_valid  one-cycle strobe, msg_* carry a complete channel message
//   msg_status status byte 0x80-0xEF
//   msg_data1  first data byte
//   msg_data2  second data byte (0x00 for one-data-byte messages)
//   msg_len    number of data bytes (1 or 2)
//   frame_err  one-cycle strobe, a byte arrived with a low stop bit
// Running status is kept across messages; real-time bytes are transparent;
// system bytes cancel running status so SysEx payload is dropped.
// -----------------------------------------------------------------------------
module midi_rx_parser
    import midi_pkg::*;
#(
    parameter int BAUD_CNT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [7:0] msg_data1,
    output logic [7:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       frame_err
);

    logic       byte_valid_s;
    logic [7:0] byte_data_s;
    logic       frame_err_s;

    logic [7:0] run_status_r;
    logic       have_status_r;
    logic       have_d1_r;
    logic [7:0] d1_r;

    midi_uart_rx #(
        .BAUD_CNT (BAUD_CNT)
    ) u_uart (
        .clk        (clk),
        .rst        (rst),
        .rx         (midi_rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .frame_err  (frame_err_s)
    );

    // The receiver's strobe is already registered.
    assign frame_err = frame_err_s;

    // Running-status message assembler with registered message outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_status_r  <= 8'h00;
            have_status_r <= 1'b0;
            have_d1_r     <= 1'b0;
            d1_r          <= 8'h00;
            msg_valid     <= 1'b0;
            msg_status    <= 8'h00;
            msg_data1     <= 8'h00;
            msg_data2     <= 8'h00;
            msg_len       <= 2'd0;
        end else begin
            msg_valid <= 1'b0;
            if (frame_err_s) begin
                // A corrupted byte breaks the current message only.
                have_d1_r <= 1'b0;
            end else if (byte_valid_s) begin
                case (midi_byte_class(byte_data_s))
                    BC_CHAN: begin
                        run_status_r  <= byte_data_s;
                        have_status_r <= 1'b1;
                        have_d1_r     <= 1'b0;
                    end
                    BC_SYS: begin
                        have_status_r <= 1'b0;
                        have_d1_r     <= 1'b0;
                    end
                    BC_DATA: begin
                        if (!have_status_r) begin
                            have_d1_r <= 1'b0;
                        end else if (have_d1_r) begin
                            msg_valid  <= 1'b1;
                            msg_status <= run_status_r;
                            msg_data1  <= d1_r;
                            msg_data2  <= byte_data_s;
                            msg_len    <= 2'd2;
                            have_d1_r  <= 1'b0;
                        end else if (midi_data_len(run_status_r) == 2'd1) begin
                            msg_valid  <= 1'b1;
                            msg_status <= run_status_r;
                            msg_data1  <= byte_data_s;
                            msg_data2  <= 8'h00;
                            msg_len    <= 2'd1;
                        end else begin
                            d1_r      <= byte_data_s;
                            have_d1_r <= 1'b1;
                        end
                    end
                    default: begin
                        // Real-time: no effect on parser state.
                        have_d1_r <= have_d1_r;
                    end
                endcase
            end else begin
                have_d1_r <= have_d1_r;
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_parser.sv
module tb_midi_rx_parser;

    localparam int BAUD = 16;
    localparam longint FE_LAT  = 2 + BAUD / 2 + 9 * BAUD + 1;
    localparam longint MSG_LAT = 2 + BAUD / 2 + 9 * BAUD + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       midi_rx = 1'b1;
    logic       msg_valid;
    logic [7:0] msg_status, msg_data1, msg_data2;
    logic [1:0] msg_len;
    logic       frame_err;

    midi_rx_parser #(.BAUD_CNT(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .midi_rx    (midi_rx),
        .msg_valid  (msg_valid),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_len    (msg_len),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
        longint     cyc;
    } msg_t;

    typedef struct {
        logic [7:0] b;
        bit         ok;
        bit         ev;
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
        bit         fe;
    } vec_t;

    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    msg_t   obs_q[$];
    msg_t   exp_q[$];
    longint obs_fe[$];
    longint exp_fe[$];

    // Reference model state: running status (-1 = none) and pending data bytes.
    int         m_rs = -1;
    logic [7:0] m_pend[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (msg_valid) obs_q.push_back('{msg_status, msg_data1, msg_data2, msg_len, cyc});
        if (frame_err) obs_fe.push_back(cyc);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rs = -1;
        m_pend.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input longint e);
        int need;
        msg_t m;
        if (!ok) begin
            exp_fe.push_back(e + FE_LAT);
            m_pend.delete();
        end else if (b >= 8'hF8) begin
            // real-time: transparent
        end else if (b >= 8'hF0) begin
            m_rs = -1;
            m_pend.delete();
        end else if (b >= 8'h80) begin
            m_rs = int'(b);
            m_pend.delete();
        end else if (m_rs >= 0) begin
            m_pend.push_back(b);
            need = ((m_rs / 16) == 12 || (m_rs / 16) == 13) ? 1 : 2;
            if (m_pend.size() == need) begin
                m.st  = 8'(m_rs);
                m.d1  = m_pend[0];
                m.d2  = (need == 2) ? m_pend[1] : 8'h00;
                m.len = 2'(need);
                m.cyc = e + MSG_LAT;
                exp_q.push_back(m);
                m_pend.delete();
            end
        end
    endtask

    // Called at a negedge; returns at a negedge right after the stop bit
    // (plus one idle bit when the stop bit is forced low).
    task automatic send_byte(input logic [7:0] b, input bit ok);
        longint e;
        midi_rx = 1'b0;
        e = cyc;
        model_byte(b, ok, e);
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        midi_rx = ok;
        repeat (BAUD) @(negedge clk);
        midi_rx = 1'b1;
        if (!ok) repeat (BAUD) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_msg_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_status"}, obs_q[i].st, exp_q[i].st);
            check({tag, "_data1"},  obs_q[i].d1, exp_q[i].d1);
            check({tag, "_data2"},  obs_q[i].d2, exp_q[i].d2);
            check({tag, "_len"},    obs_q[i].len, exp_q[i].len);
            check({tag, "_msg_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
        end
        check({tag, "_fe_count"}, obs_fe.size(), exp_fe.size());
        for (int i = 0; i < exp_fe.size() && i < obs_fe.size(); i++)
            check({tag, "_fe_cycle"}, obs_fe[i], exp_fe[i]);
        obs_q.delete(); exp_q.delete(); obs_fe.delete(); exp_fe.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  msg_valid, 0);
        check({tag, "_fe"},     frame_err, 0);
        check({tag, "_status"}, msg_status, 0);
        check({tag, "_data1"},  msg_data1, 0);
        check({tag, "_data2"},  msg_data2, 0);
        check({tag, "_len"},    msg_len, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int n0, f0;
        vecs = '{
            '{8'h90, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h3C, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h64, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd2, 0},
            '{8'h3E, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h00, 1, 1, 8'h90, 8'h3E, 8'h00, 2'd2, 0},
            '{8'hC0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h42, 1, 1, 8'hC0, 8'h42, 8'h00, 2'd1, 0},
            '{8'hB0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h2E, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h7F, 1, 1, 8'hB0, 8'h2E, 8'h7F, 2'd2, 0},
            '{8'h90, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'hF8, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h3C, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'hFE, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h64, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd2, 0},
            '{8'h90, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h3C, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1},
            '{8'h3D, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h40, 1, 1, 8'h90, 8'h3D, 8'h40, 2'd2, 0},
            '{8'hF0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h01, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'hF7, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0},
            '{8'h10, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0}
        };

        // Reset
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("post_reset");

        // Directed table, bytes sent back-to-back
        for (int v = 0; v < vecs.size(); v++) begin
            n0 = obs_q.size();
            f0 = obs_fe.size();
            send_byte(vecs[v].b, vecs[v].ok);
            check($sformatf("vec%0d_strobe", v), obs_q.size() - n0, vecs[v].ev ? 1 : 0);
            check($sformatf("vec%0d_frame_err", v), obs_fe.size() - f0, vecs[v].fe ? 1 : 0);
            if (vecs[v].ev && obs_q.size() > n0) begin
                check($sformatf("vec%0d_status", v), obs_q[n0].st, vecs[v].st);
                check($sformatf("vec%0d_data1", v),  obs_q[n0].d1, vecs[v].d1);
                check($sformatf("vec%0d_data2", v),  obs_q[n0].d2, vecs[v].d2);
                check($sformatf("vec%0d_len", v),    obs_q[n0].len, vecs[v].len);
            end
        end
        repeat (8) @(negedge clk);
        drain_check("table");

        // Short glitch must not start a byte; a following message stays aligned
        send_byte(8'h90, 1'b1);
        repeat (20) @(negedge clk);
        midi_rx = 1'b0;
        repeat (4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        repeat (8) @(negedge clk);
        drain_check("glitch");
        check("glitch_hold_status", msg_status, 8'h90);
        check("glitch_hold_data2", msg_data2, 8'h64);

        // Reset in the middle of a byte
        midi_rx = 1'b0;
        repeat (BAUD * 3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midbyte_reset");
        rst = 1'b1;
        midi_rx = 1'b1;
        model_reset();
        repeat (BAUD * 12) @(negedge clk);
        check_reset_outputs("after_midbyte_reset");
        send_byte(8'h3C, 1'b1);    // running status was cleared: dropped
        send_byte(8'h64, 1'b1);
        send_byte(8'hD3, 1'b1);
        send_byte(8'h7F, 1'b1);
        repeat (8) @(negedge clk);
        drain_check("post_reset_stream");

        // Randomized stream against the reference model
        for (int k = 0; k < 60; k++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4 || r == 9) b = 8'($urandom_range(0, 127));
            else if (r <= 6)      b = 8'($urandom_range(128, 239));
            else if (r == 7)      b = 8'($urandom_range(248, 255));
            else                  b = 8'($urandom_range(240, 247));
            send_byte(b, $urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        drain_check("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
